// File: rtl/gene_attractor_detector.sv
// ---------------------------------------------------------------------------
// gene_attractor_detector
//
// Watches the state trajectory of the gene regulatory network stage. After a
// start pulse, every valid x_in is compared against the states already seen.
// The first state that repeats ends the capture, and the detector reports:
//   - the attractor period,
//   - the transient length (states seen before the cycle was entered),
//   - the repeated state itself.
// If the history fills up with no repeat, the detector reports overflow
// (found=0, transient=DEPTH).
//
// Parameters
//   WIDTH  gene state width (must match the network state width)
//   DEPTH  history entries, power of two in 2..32
//   CW     width of count/period/transient, $clog2(DEPTH)+1
//
// Ports
//   clk         clock; all state changes on the rising edge
//   n_reset     synchronous, active-low reset
//   start       one-cycle pulse that begins (or restarts) a capture
//   valid       x_in carries a new network state this cycle
//   x_in        network state sample
//   busy        high while a trajectory is being tracked
//   done        high while results are held
//   found       1 = repeat detected, 0 = history overflow
//   period      attractor cycle length (1 = fixed point)
//   transient   number of states before the attractor was entered
//   attr_state  first repeated state (last sample on overflow)
// ---------------------------------------------------------------------------
module gene_attractor_detector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] x_in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [CW-1:0]    period,
    output logic [CW-1:0]    transient,
    output logic [WIDTH-1:0] attr_state
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // History is left unreset: entries at or above count are never compared,
    // so stale contents cannot cause a false match.
    logic [WIDTH-1:0] hist [DEPTH];
    logic [CW-1:0]    count;

    logic             hit;
    logic [CW-1:0]    hit_idx;
    logic             accept;
    logic             last_slot;

    // A sample is taken only while tracking, and never on a restart cycle.
    assign accept    = (state == TRACK) && valid && !start;
    assign last_slot = (count == CW'(DEPTH - 1));

    // Parallel compare against committed entries. Scanning from the top down
    // lets the lowest matching index win, since it is assigned last.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count) && (hist[i] == x_in)) begin
                hit     = 1'b1;
                hit_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs. start always (re)enters TRACK, which
    // also covers the abort-and-restart case while already tracking.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                busy = 1'b1;
                if (start) begin
                    state_next = TRACK;
                end else if (valid && (hit || last_slot)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = TRACK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Count and registered results. A start pulse clears everything so a
    // fresh capture never shows results from the previous one.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count      <= '0;
            found      <= 1'b0;
            period     <= '0;
            transient  <= '0;
            attr_state <= '0;
        end else if (start) begin
            count      <= '0;
            found      <= 1'b0;
            period     <= '0;
            transient  <= '0;
            attr_state <= '0;
        end else if (accept) begin
            if (hit) begin
                found      <= 1'b1;
                period     <= count - hit_idx;
                transient  <= hit_idx;
                attr_state <= x_in;
            end else if (last_slot) begin
                // Overflow: count is left at DEPTH-1, the history is full.
                found      <= 1'b0;
                period     <= '0;
                transient  <= CW'(DEPTH);
                attr_state <= x_in;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // A sample that did not repeat is committed, including the final one on
    // overflow.
    always_ff @(posedge clk) begin
        if (n_reset && accept && !hit) begin
            hist[count[IW-1:0]] <= x_in;
        end
    end

endmodule

// File: tb/tb_gene_attractor_detector.sv
// ---------------------------------------------------------------------------
// tb_gene_attractor_detector
//
// Directed scenarios for fixed points, transients, overflow, valid gaps,
// restart and reset, followed by randomized trajectories scored against a
// queue-based reference model of "first repeated state".
// ---------------------------------------------------------------------------
module tb_gene_attractor_detector;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             n_reset;
    logic             start;
    logic             valid;
    logic [WIDTH-1:0] x_in;
    logic             busy;
    logic             done;
    logic             found;
    logic [CW-1:0]    period;
    logic [CW-1:0]    transient;
    logic [WIDTH-1:0] attr_state;

    int total = 0;
    int bad   = 0;

    gene_attractor_detector #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start),
        .valid     (valid),
        .x_in      (x_in),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .period    (period),
        .transient (transient),
        .attr_state(attr_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, let the edge happen, then settle.
    task automatic applyStimulus(input logic s, input logic v, input logic [WIDTH-1:0] x);
        start = s;
        valid = v;
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic f, input int p,
                               input int t, input logic [WIDTH-1:0] a);
        checkOutput({tag, "_done"},      32'(done),       32'd1);
        checkOutput({tag, "_busy"},      32'(busy),       32'd0);
        checkOutput({tag, "_found"},     32'(found),      32'(f));
        checkOutput({tag, "_period"},    32'(period),     32'(p));
        checkOutput({tag, "_transient"}, 32'(transient),  32'(t));
        checkOutput({tag, "_attr"},      32'(attr_state), 32'(a));
    endtask

    task automatic checkCleared(input string tag, input logic exp_busy);
        checkOutput({tag, "_busy"},      32'(busy),       32'(exp_busy));
        checkOutput({tag, "_done"},      32'(done),       32'd0);
        checkOutput({tag, "_found"},     32'(found),      32'd0);
        checkOutput({tag, "_period"},    32'(period),     32'd0);
        checkOutput({tag, "_transient"}, 32'(transient),  32'd0);
        checkOutput({tag, "_attr"},      32'(attr_state), 32'd0);
    endtask

    task automatic checkTracking(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Random trajectory scored against a list of states seen so far: the
    // answer is the position of the first earlier occurrence of a sample.
    task automatic runTrial(input int alpha, input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] seen[$];
        logic             finished;
        logic             exp_found;
        int               exp_period;
        int               exp_transient;
        logic [WIDTH-1:0] exp_attr;
        logic             s;
        logic             v;
        logic [WIDTH-1:0] x;
        int               idx;
        int               cycles;

        finished      = 1'b0;
        exp_found     = 1'b0;
        exp_period    = 0;
        exp_transient = 0;
        exp_attr      = '0;
        cycles        = 0;
        applyStimulus(1'b1, 1'b0, '0);
        checkCleared("rnd_start", 1'b1);
        while (!finished && cycles < 200) begin
            cycles++;
            s = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 3) != 0);
            x = base + WIDTH'($urandom_range(0, alpha - 1));
            applyStimulus(s, v, x);
            if (s) begin
                seen.delete();
            end else if (v) begin
                idx = -1;
                foreach (seen[k]) begin
                    if (idx < 0 && seen[k] == x) idx = k;
                end
                if (idx >= 0) begin
                    exp_found     = 1'b1;
                    exp_period    = seen.size() - idx;
                    exp_transient = idx;
                    exp_attr      = x;
                    finished      = 1'b1;
                end else begin
                    seen.push_back(x);
                    if (seen.size() == DEPTH) begin
                        exp_found     = 1'b0;
                        exp_period    = 0;
                        exp_transient = DEPTH;
                        exp_attr      = x;
                        finished      = 1'b1;
                    end
                end
            end
            if (finished) begin
                checkResult("rnd", exp_found, exp_period, exp_transient, exp_attr);
            end else begin
                checkTracking("rnd_track");
            end
        end
        checkOutput("rnd_finished", 32'(done), 32'd1);
    endtask

    initial begin
        n_reset = 1'b0;
        start   = 1'b0;
        valid   = 1'b0;
        x_in    = '0;

        // Reset state
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 8'h33);
        checkCleared("reset", 1'b0);
        n_reset = 1'b1;

        // valid alone in IDLE does nothing
        applyStimulus(1'b0, 1'b1, 8'h12);
        checkCleared("idle_valid", 1'b0);

        $display("[TB] fixed point");
        applyStimulus(1'b1, 1'b0, '0);
        checkCleared("fp_start", 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkTracking("fp_s0");
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkResult("fp", 1'b1, 1, 0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkResult("fp_hold", 1'b1, 1, 0, 8'h00);

        $display("[TB] transient plus cycle");
        applyStimulus(1'b1, 1'b0, '0);
        checkCleared("tc_clear", 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b1, 8'h22);
        applyStimulus(1'b0, 1'b1, 8'h33);
        checkTracking("tc_s2");
        applyStimulus(1'b0, 1'b1, 8'h22);
        checkResult("tc", 1'b1, 2, 1, 8'h22);

        $display("[TB] overflow");
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus(1'b0, 1'b1, WIDTH'(i));
        end
        checkTracking("ov_s14");
        applyStimulus(1'b0, 1'b1, WIDTH'(DEPTH - 1));
        checkResult("ov", 1'b0, 0, DEPTH, 8'h0F);

        $display("[TB] valid gaps");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h40);
            checkTracking("gap");
        end
        applyStimulus(1'b0, 1'b1, 8'h41);
        applyStimulus(1'b0, 1'b1, 8'h40);
        checkResult("gap", 1'b1, 2, 0, 8'h40);

        $display("[TB] abort and restart");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 8'h05);
        applyStimulus(1'b0, 1'b1, 8'h06);
        applyStimulus(1'b1, 1'b1, 8'h06);
        checkCleared("abort_start", 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h06);
        checkTracking("abort_s0");
        applyStimulus(1'b0, 1'b1, 8'h07);
        checkTracking("abort_s1");
        applyStimulus(1'b0, 1'b1, 8'h06);
        checkResult("abort", 1'b1, 2, 0, 8'h06);

        $display("[TB] reset mid-track");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h03);
        n_reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h01);
        checkCleared("rst_mid", 1'b0);
        n_reset = 1'b1;
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkResult("rst_after", 1'b1, 1, 0, 8'h00);

        $display("[TB] randomized trajectories");
        for (int t = 0; t < 40; t++) begin
            runTrial($urandom_range(2, 40), WIDTH'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
